// File: rtl/hilo_muldiv.sv
// hilo_muldiv: HI/LO register pair with single-cycle multiply and iterative radix-2 restoring divide
module hilo_muldiv #(
    parameter int WIDTH = 32,
    parameter logic [4:0] MULT_CONTROL  = 5'h18,
    parameter logic [4:0] MULTU_CONTROL = 5'h19,
    parameter logic [4:0] DIV_CONTROL   = 5'h1a,
    parameter logic [4:0] DIVU_CONTROL  = 5'h1b,
    parameter logic [4:0] MTHI_CONTROL  = 5'h1c,
    parameter logic [4:0] MTLO_CONTROL  = 5'h1d
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic [4:0]       alucontrol,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             flush,
    output logic             stall_o,
    output logic [WIDTH-1:0] hi_o,
    output logic [WIDTH-1:0] lo_o
);
    localparam int CW = $clog2(WIDTH);

    typedef enum logic [1:0] {IDLE, RUN, FIX, DONE} state_t;

    state_t           state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [WIDTH-1:0] hi_q, hi_d, lo_q, lo_d;
    logic [WIDTH-1:0] rem_q, rem_d, quo_q, quo_d, dvs_q, dvs_d;
    logic             qneg_q, qneg_d, rneg_q, rneg_d;

    logic             is_mul, is_div, sdiv, div_go;
    logic [2*WIDTH-1:0] ae, be, prod;
    logic [WIDTH:0]   trial, diff;

    assign is_mul = alucontrol == MULT_CONTROL || alucontrol == MULTU_CONTROL;
    assign is_div = alucontrol == DIV_CONTROL || alucontrol == DIVU_CONTROL;
    assign sdiv   = alucontrol == DIV_CONTROL;
    assign div_go = en && state_q == IDLE && is_div && b != '0;
    // Sign-extending both operands to 2*WIDTH lets one multiplier serve MULT and MULTU.
    assign ae     = {{WIDTH{alucontrol == MULT_CONTROL && a[WIDTH-1]}}, a};
    assign be     = {{WIDTH{alucontrol == MULT_CONTROL && b[WIDTH-1]}}, b};
    assign prod   = ae * be;
    // Partial remainder shifted left with the next dividend bit; needs one extra bit.
    assign trial  = {rem_q, quo_q[WIDTH-1]};
    assign diff   = trial - {1'b0, dvs_q};
    assign stall_o = div_go || state_q == RUN || state_q == FIX;
    assign hi_o   = hi_q;
    assign lo_o   = lo_q;

    // Next-state logic for the divider FSM, datapath and HI/LO writes; flush overrides everything.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        hi_d    = hi_q;
        lo_d    = lo_q;
        rem_d   = rem_q;
        quo_d   = quo_q;
        dvs_d   = dvs_q;
        qneg_d  = qneg_q;
        rneg_d  = rneg_q;
        case (state_q)
            IDLE: begin
                if (en && is_mul) {hi_d, lo_d} = prod;
                if (en && alucontrol == MTHI_CONTROL) hi_d = a;
                if (en && alucontrol == MTLO_CONTROL) lo_d = a;
                if (div_go) begin
                    state_d = RUN;
                    cnt_d   = '0;
                    rem_d   = '0;
                    quo_d   = sdiv && a[WIDTH-1] ? -a : a;
                    dvs_d   = sdiv && b[WIDTH-1] ? -b : b;
                    qneg_d  = sdiv && (a[WIDTH-1] ^ b[WIDTH-1]);
                    rneg_d  = sdiv && a[WIDTH-1];
                end
            end
            RUN: begin
                rem_d   = diff[WIDTH] ? trial[WIDTH-1:0] : diff[WIDTH-1:0];
                quo_d   = {quo_q[WIDTH-2:0], ~diff[WIDTH]};
                cnt_d   = cnt_q + CW'(1);
                state_d = cnt_q == CW'(WIDTH-1) ? FIX : RUN;
            end
            FIX: begin
                lo_d    = qneg_q ? -quo_q : quo_q;
                hi_d    = rneg_q ? -rem_q : rem_q;
                state_d = DONE;
            end
            default: state_d = IDLE;
        endcase
        if (flush) begin
            state_d = IDLE;
            hi_d    = hi_q;
            lo_d    = lo_q;
        end
    end

    // State and datapath registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            hi_q    <= '0;
            lo_q    <= '0;
            rem_q   <= '0;
            quo_q   <= '0;
            dvs_q   <= '0;
            qneg_q  <= 1'b0;
            rneg_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
            rem_q   <= rem_d;
            quo_q   <= quo_d;
            dvs_q   <= dvs_d;
            qneg_q  <= qneg_d;
            rneg_q  <= rneg_d;
        end
    end
endmodule

// File: tb/tb_hilo_muldiv.sv
// tb_hilo_muldiv: randomized and directed checks of hilo_muldiv against an arithmetic HI/LO model
module tb_hilo_muldiv;
    localparam int W = 32;
    localparam logic [4:0] C_MULT = 5'h18, C_MULTU = 5'h19, C_DIV = 5'h1a;
    localparam logic [4:0] C_DIVU = 5'h1b, C_MTHI = 5'h1c, C_MTLO = 5'h1d;

    logic         clk = 1'b0;
    logic         rst, en, flush, stall_o;
    logic [4:0]   alucontrol;
    logic [W-1:0] a, b, hi_o, lo_o;
    logic [W-1:0] hi_m = '0, lo_m = '0;
    int           checks = 0, errors = 0;

    hilo_muldiv #(
        .WIDTH(W), .MULT_CONTROL(C_MULT), .MULTU_CONTROL(C_MULTU), .DIV_CONTROL(C_DIV),
        .DIVU_CONTROL(C_DIVU), .MTHI_CONTROL(C_MTHI), .MTLO_CONTROL(C_MTLO)
    ) dut (
        .clk(clk), .rst(rst), .en(en), .alucontrol(alucontrol), .a(a), .b(b),
        .flush(flush), .stall_o(stall_o), .hi_o(hi_o), .lo_o(lo_o)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic void model(input logic [4:0] c, input logic [W-1:0] x, input logic [W-1:0] y);
        longint      p;
        logic [63:0] u;
        case (c)
            C_MULT: begin
                p = longint'($signed(x)) * longint'($signed(y));
                {hi_m, lo_m} = p;
            end
            C_MULTU: begin
                u = {32'b0, x} * {32'b0, y};
                {hi_m, lo_m} = u;
            end
            C_DIV: if (y != 0) begin
                p    = longint'($signed(x));
                lo_m = W'(p / longint'($signed(y)));
                hi_m = W'(p % longint'($signed(y)));
            end
            C_DIVU: if (y != 0) begin
                lo_m = x / y;
                hi_m = x % y;
            end
            C_MTHI: hi_m = x;
            C_MTLO: lo_m = x;
            default: ;
        endcase
    endfunction

    task automatic op(input logic [4:0] c, input logic [W-1:0] x, input logic [W-1:0] y, input bit inj);
        int n;
        bit dv;
        dv = (c == C_DIV || c == C_DIVU) && y != 0;
        en = 1'b1; alucontrol = c; a = x; b = y;
        model(c, x, y);
        if (!dv) begin
            #1 check("stall_nodiv", 32'(stall_o), 0);
            @(posedge clk); #1;
            en = 1'b0;
        end else begin
            n = 0;
            while (n < 100) begin
                #1;
                if (!stall_o) break;
                n++;
                alucontrol = (inj && n == 5) ? C_MULT : c;
                @(posedge clk); #1;
            end
            check("stall_cycles", 32'(n), 34);
            check("done_hi", hi_o, hi_m);
            check("done_lo", lo_o, lo_m);
            @(posedge clk); #1;
            en = 1'b0;
            #1 check("no_reaccept", 32'(stall_o), 0);
        end
        check("hi", hi_o, hi_m);
        check("lo", lo_o, lo_m);
    endtask

    task automatic abort(input bit use_rst, input int at);
        en = 1'b1; alucontrol = C_DIVU; a = 100; b = 7;
        @(posedge clk); #1;
        en = 1'b0;
        repeat (at - 1) begin @(posedge clk); #1; end
        #1 check("stall_run", 32'(stall_o), 1);
        if (use_rst) rst = 1'b1; else flush = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0; flush = 1'b0;
        if (use_rst) begin hi_m = '0; lo_m = '0; end
        #1 check("stall_abort", 32'(stall_o), 0);
        check("abort_hi", hi_o, hi_m);
        check("abort_lo", lo_o, lo_m);
        repeat (40) @(posedge clk);
        #1 check("abort_hi_late", hi_o, hi_m);
        check("abort_lo_late", lo_o, lo_m);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "timeout");
    end

    initial begin
        logic [4:0]   codes [6];
        logic [W-1:0] x, y;
        codes = '{C_MULT, C_MULTU, C_DIV, C_DIVU, C_MTHI, C_MTLO};
        rst = 1'b1; en = 1'b0; flush = 1'b0; alucontrol = '0; a = '0; b = '0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        #1 check("rst_stall", 32'(stall_o), 0);
        check("rst_hi", hi_o, 0);
        check("rst_lo", lo_o, 0);

        op(C_MULT, 32'hFFFFFFFF, 32'h2, 0);
        check("mult_hi_k", hi_o, 32'hFFFFFFFF);
        check("mult_lo_k", lo_o, 32'hFFFFFFFE);
        op(C_MULTU, 32'hFFFFFFFF, 32'h2, 0);
        check("multu_hi_k", hi_o, 32'h1);
        op(C_DIV, 32'hFFFFFFF9, 32'h2, 0);
        check("div_lo_k", lo_o, 32'hFFFFFFFD);
        check("div_hi_k", hi_o, 32'hFFFFFFFF);
        op(C_DIVU, 100, 7, 0);
        check("divu_lo_k", lo_o, 14);
        check("divu_hi_k", hi_o, 2);
        op(C_DIV, 32'h80000000, 32'hFFFFFFFF, 0);
        check("ovf_lo_k", lo_o, 32'h80000000);
        check("ovf_hi_k", hi_o, 0);
        op(C_MTHI, 32'h1234, 0, 0);
        op(C_MTLO, 32'h5678, 0, 0);
        op(C_DIV, 5, 0, 0);
        check("div0_hi_k", hi_o, 32'h1234);
        check("div0_lo_k", lo_o, 32'h5678);

        abort(0, 10);
        abort(1, 20);

        en = 1'b1; alucontrol = C_MTLO; a = 32'hDEADBEEF; flush = 1'b1;
        @(posedge clk); #1;
        en = 1'b0; flush = 1'b0;
        check("mtlo_flush", lo_o, lo_m);

        op(C_DIVU, 1000, 3, 1);
        op(C_DIV, 32'hFFFF0000, 32'h7, 1);

        for (int i = 0; i < 40; i++) begin
            x = $urandom;
            y = ($urandom_range(7) == 0) ? '0 : $urandom;
            if ($urandom_range(9) == 0) begin x = 32'h80000000; y = 32'hFFFFFFFF; end
            if ($urandom_range(3) == 0) y = y >> $urandom_range(31);
            op(codes[$urandom_range(5)], x, y, bit'($urandom_range(1)));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/hilo_muldiv.md
Name: hilo_muldiv

Overview:
- Execute-stage consumer of the 5-bit alucontrol code produced by instruction decode.
- Executes the MULT_CONTROL, MULTU_CONTROL, DIV_CONTROL, DIVU_CONTROL, MTHI_CONTROL and MTLO_CONTROL codes from defines.vh against the architectural HI/LO pair. HI and LO are always visible for MFHI/MFLO forwarding.
- Multiplies complete in one cycle. Divides use an iterative radix-2 restoring divider that stalls the pipeline.

Parameters:
- WIDTH, 32, operand/HI/LO width; iteration count equals WIDTH.

Ports:
- clk  input  1  clock.
- rst  input  1  synchronous active-high reset.
- en  input  1  E-stage instruction valid; qualifies alucontrol.
- alucontrol  input  5  operation code (defines.vh encodings).
- a  input  WIDTH  rs operand (dividend / multiplicand / MTHI-MTLO source).
- b  input  WIDTH  rt operand (divisor / multiplier).
- flush  input  1  abort in-flight divide; suppress writes this cycle.
- stall_o  output  1  hold the pipeline.
- hi_o  output  WIDTH  current HI.
- lo_o  output  WIDTH  current LO.

Behaviour:
- Reset
  - Synchronous, on rst high at a clk edge.
  - hi_o = 0, lo_o = 0, state = IDLE, iteration counter = 0, stall_o = 0.
- Priority: rst > flush > operation. flush forces state to IDLE and blocks every HI/LO write in that cycle.
- Accept rule: an operation is accepted only when en = 1 and state = IDLE.
  - Other codes are ignored.
  - en with any code is ignored in RUN, FIX and DONE.
- MULT/MULTU
  - Full 2*WIDTH product, signed or unsigned.
  - HI = upper half, LO = lower half, written at the edge ending the issue cycle.
  - stall_o stays 0.
- MTHI / MTLO: HI (or LO) = a at the edge ending the issue cycle; the other register is unchanged.
- Divide by zero (DIV/DIVU with b = 0): no state change, no stall, HI/LO unchanged.
- DIV/DIVU with b != 0, state machine IDLE -> RUN -> FIX -> DONE -> IDLE.
  - Issue cycle (IDLE): stall_o = 1 combinationally. Latch |a|, |b| (magnitudes for DIV, raw values for DIVU), the quotient sign (a[MSB]^b[MSB], DIV only) and the remainder sign (a[MSB], DIV only). Clear the counter. Next state RUN.
  - RUN: one restoring iteration per cycle (shift partial remainder, trial subtract, set quotient bit). Counter increments; after WIDTH iterations (counter = WIDTH-1 at the edge) go to FIX. stall_o = 1.
  - FIX: apply the sign corrections and write LO = quotient and HI = remainder at the edge ending FIX. stall_o = 1. Next state DONE.
  - DONE: stall_o = 0. The still-present DIV in E is not re-accepted. Next state IDLE unconditionally.
  - Total stall: WIDTH+2 = 34 cycles including the issue cycle. New HI/LO is visible on hi_o/lo_o during DONE.
- Signed results
  - Quotient truncates toward zero; remainder takes the sign of the dividend.
  - 0x80000000 / 0xFFFFFFFF gives LO = 0x80000000, HI = 0, with no exception.
- flush
  - In RUN or FIX: state goes to IDLE next edge and stall_o drops that next cycle; HI/LO unchanged.
  - In the issue cycle: the divide is not started.
  - In DONE: no effect beyond returning to IDLE.
- rst mid-divide: the reset values apply; no partial result is written.
- stall_o is combinational from state, en, alucontrol and b only; no dependency on hi_o/lo_o.

Test Plan:
- Reset, then MULT a=0xFFFFFFFF b=0x00000002 -> next cycle HI=0xFFFFFFFF, LO=0xFFFFFFFE, stall_o never 1. Then MULTU with the same operands -> HI=0x00000001, LO=0xFFFFFFFE.
- DIV a=0xFFFFFFF9 (-7) b=2 with en held while stalled -> stall_o high exactly 34 consecutive cycles; in DONE LO=0xFFFFFFFD, HI=0xFFFFFFFF; no second divide starts.
- DIVU a=100 b=7 -> LO=14, HI=2 after 34 stall cycles. Then DIV a=0x80000000 b=0xFFFFFFFF -> LO=0x80000000, HI=0.
- Preload via MTHI 0x1234, MTLO 0x5678, then DIV a=5 b=0 -> stall_o stays 0; HI=0x1234, LO=0x5678 unchanged.
- Start DIVU 100/7, assert flush in RUN cycle 10 -> stall_o 0 the next cycle, state IDLE, HI/LO hold prior values. Repeat with rst in RUN cycle 20 -> HI=LO=0, stall_o=0.
- MTLO with flush in the same cycle -> LO unchanged. MULT issued while in RUN -> ignored; HI/LO equal the divide result only.
